alarm_set_ctrl: RTL and testbench

Sequencing controller for the alarm-clock display path. It turns two debounced button pulses into a field-select state machine that edits a stored HH:MM:SS alarm time in BCD. It compares that alarm time with the running clock and drives a timed ring output. Its `selection` and six alarm BCD digits feed the VGA text renderer directly, which highlights the field being edited.

---
 rtl/alarm_pkg.sv | 13 +
 rtl/bcd2_inc.sv | 29 ++
 rtl/alarm_set_ctrl.sv | 110 +++++++++++
 tb/tb_alarm_set_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared state codes and BCD field limits for the alarm-set controller.
// State codes double as the selection value seen by the text renderer.
package alarm_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEC  = 2'd1;
    localparam logic [1:0] ST_MIN  = 2'd2;
    localparam logic [1:0] ST_HOUR = 2'd3;

    // Upper limits written as BCD pairs {msb, lsb}
    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MAX = 8'h23;
endpackage

// File: rtl/bcd2_inc.sv
// Two-digit BCD register that steps by one on inc and wraps to 00 after
// {MAX_MSB, MAX_LSB}; no carry leaves the field.
module bcd2_inc #(
    parameter logic [3:0] MAX_MSB = 4'd5,
    parameter logic [3:0] MAX_LSB = 4'd9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    output logic [3:0] msb,
    output logic [3:0] lsb
);
    always_ff @(posedge clk) begin
        if (reset) begin
            msb <= 4'd0;
            lsb <= 4'd0;
        end else if (inc) begin
            if (msb == MAX_MSB && lsb == MAX_LSB) begin
                msb <= 4'd0;
                lsb <= 4'd0;
            end else if (lsb == 4'd9) begin
                msb <= msb + 4'd1;
                lsb <= 4'd0;
            end else begin
                lsb <= lsb + 4'd1;
            end
        end
    end
endmodule

// File: rtl/alarm_set_ctrl.sv
// Alarm field-select FSM, BCD alarm storage, match edge detector and timed
// ring output. Every output is a register.
module alarm_set_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_SECONDS = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       alarm_en,
    input  logic       sec_tick,
    input  logic [3:0] cur_hourMSB,
    input  logic [3:0] cur_hourLSB,
    input  logic [3:0] cur_minMSB,
    input  logic [3:0] cur_minLSB,
    input  logic [3:0] cur_secMSB,
    input  logic [3:0] cur_secLSB,
    output logic [1:0] selection,
    output logic [3:0] alarm_hourMSB,
    output logic [3:0] alarm_hourLSB,
    output logic [3:0] alarm_minMSB,
    output logic [3:0] alarm_minLSB,
    output logic [3:0] alarm_secMSB,
    output logic [3:0] alarm_secLSB,
    output logic       ring
);
    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [7:0] ring_cnt;
    logic       match_r;
    logic       match_d;
    logic       match_now;
    logic       trigger;
    logic       dismiss;
    logic       up_only;

    // Mode has priority over up when both pulse together
    assign up_only = btn_up && !btn_mode;

    assign match_now = (cur_hourMSB == alarm_hourMSB) && (cur_hourLSB == alarm_hourLSB) &&
                       (cur_minMSB  == alarm_minMSB)  && (cur_minLSB  == alarm_minLSB)  &&
                       (cur_secMSB  == alarm_secMSB)  && (cur_secLSB  == alarm_secLSB);

    assign trigger = match_r && !match_d && (state == ST_IDLE) && alarm_en;
    assign dismiss = btn_up || btn_mode || !alarm_en;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: state_nxt = ST_SEC;
            ST_SEC:  state_nxt = ST_MIN;
            ST_MIN:  state_nxt = ST_HOUR;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A mode pulse spent on dismissing the ring does not also advance the FSM
    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else if (btn_mode && !ring)
            state <= state_nxt;
    end

    assign selection = state;

    bcd2_inc #(.MAX_MSB(SEC_MAX[7:4]), .MAX_LSB(SEC_MAX[3:0])) u_sec (
        .clk(clk), .reset(reset), .inc(up_only && state == ST_SEC),
        .msb(alarm_secMSB), .lsb(alarm_secLSB)
    );

    bcd2_inc #(.MAX_MSB(MIN_MAX[7:4]), .MAX_LSB(MIN_MAX[3:0])) u_min (
        .clk(clk), .reset(reset), .inc(up_only && state == ST_MIN),
        .msb(alarm_minMSB), .lsb(alarm_minLSB)
    );

    bcd2_inc #(.MAX_MSB(HOUR_MAX[7:4]), .MAX_LSB(HOUR_MAX[3:0])) u_hour (
        .clk(clk), .reset(reset), .inc(up_only && state == ST_HOUR),
        .msb(alarm_hourMSB), .lsb(alarm_hourLSB)
    );

    // Dismiss beats a fresh trigger; a fresh load beats a same-cycle tick
    always_ff @(posedge clk) begin
        if (reset) begin
            match_r  <= 1'b0;
            match_d  <= 1'b0;
            ring     <= 1'b0;
            ring_cnt <= 8'd0;
        end else begin
            match_r <= match_now;
            match_d <= match_r;
            if (ring && dismiss) begin
                ring     <= 1'b0;
                ring_cnt <= 8'd0;
            end else if (trigger) begin
                ring     <= 1'b1;
                ring_cnt <= 8'(RING_SECONDS);
            end else if (ring && sec_tick) begin
                if (ring_cnt <= 8'd1) begin
                    ring     <= 1'b0;
                    ring_cnt <= 8'd0;
                end else begin
                    ring_cnt <= ring_cnt - 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Directed bench for alarm_set_ctrl: stimulus queues expected output
// snapshots by cycle, a negedge monitor pops and compares them.
module tb_alarm_set_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        btn_mode, btn_up, alarm_en, sec_tick;
    logic [23:0] cur_t;
    logic [1:0]  selection;
    logic [3:0]  alarm_hourMSB, alarm_hourLSB, alarm_minMSB, alarm_minLSB;
    logic [3:0]  alarm_secMSB, alarm_secLSB;
    logic        ring;
    logic [23:0] al;

    typedef struct {
        int          cyc;
        string       name;
        logic [1:0]  sel;
        logic [23:0] al;
        logic        ring;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [1:0]  e_sel;
    logic [23:0] e_al;
    logic        e_ring;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alarm_set_ctrl #(.RING_SECONDS(3)) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_up(btn_up),
        .alarm_en(alarm_en), .sec_tick(sec_tick),
        .cur_hourMSB(cur_t[23:20]), .cur_hourLSB(cur_t[19:16]),
        .cur_minMSB(cur_t[15:12]),  .cur_minLSB(cur_t[11:8]),
        .cur_secMSB(cur_t[7:4]),    .cur_secLSB(cur_t[3:0]),
        .selection(selection),
        .alarm_hourMSB(alarm_hourMSB), .alarm_hourLSB(alarm_hourLSB),
        .alarm_minMSB(alarm_minMSB),   .alarm_minLSB(alarm_minLSB),
        .alarm_secMSB(alarm_secMSB),   .alarm_secLSB(alarm_secLSB),
        .ring(ring)
    );

    assign al = {alarm_hourMSB, alarm_hourLSB, alarm_minMSB, alarm_minLSB,
                 alarm_secMSB, alarm_secLSB};

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc || selection !== e.sel || al !== e.al || ring !== e.ring) begin
                errors++;
                $display("FAIL %s: got sel=%0d alarm=%h ring=%0b at cyc %0d, want sel=%0d alarm=%h ring=%0b at cyc %0d",
                         e.name, selection, al, ring, cyc, e.sel, e.al, e.ring, e.cyc);
            end
        end
    end

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string nm);
        exp_t x;
        x.cyc  = cyc;
        x.name = nm;
        x.sel  = e_sel;
        x.al   = e_al;
        x.ring = e_ring;
        sb.push_back(x);
    endtask

    // Inputs live for exactly one cycle, then return to zero
    task automatic cycle_in(input bit m, input bit u, input bit t);
        btn_mode = m;
        btn_up   = u;
        sec_tick = t;
        @(posedge clk);
        #1;
        btn_mode = 1'b0;
        btn_up   = 1'b0;
        sec_tick = 1'b0;
    endtask

    task automatic mode(input string nm);
        cycle_in(1'b1, 1'b0, 1'b0);
        e_sel = e_sel + 2'd1;
        chk(nm);
    endtask

    // Break the match for one cycle, restore it; ring rises 2 cycles later
    task automatic retrigger(input bit tick, input string nm);
        cur_t = 24'h073006;
        cycle_in(1'b0, 1'b0, 1'b0);
        cur_t = 24'h073005;
        cycle_in(1'b0, 1'b0, 1'b0);
        cycle_in(1'b0, 1'b0, tick);
        e_ring = 1'b1;
        chk(nm);
    endtask

    initial begin
        reset = 1'b1; btn_mode = 1'b0; btn_up = 1'b0; sec_tick = 1'b0;
        alarm_en = 1'b0; cur_t = 24'h222222;
        e_sel = 2'd0; e_al = 24'h000000; e_ring = 1'b0;
        @(posedge clk); #1;
        cycle_in(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        chk("reset_state");

        for (int i = 0; i < 4; i++) mode("mode_step");

        mode("enter_sec");
        for (int i = 1; i <= 60; i++) begin
            cycle_in(1'b0, 1'b1, 1'b0);
            e_al[7:0] = bcd(i % 60);
            chk("sec_inc");
        end

        mode("enter_min");
        mode("enter_hour");
        for (int i = 1; i <= 24; i++) begin
            cycle_in(1'b0, 1'b1, 1'b0);
            e_al[23:16] = bcd(i % 24);
            chk("hour_inc");
        end

        mode("back_idle");
        mode("set_sec");
        for (int i = 1; i <= 5; i++) begin
            cycle_in(1'b0, 1'b1, 1'b0);
            e_al[7:0] = bcd(i);
            chk("set_sec_inc");
        end
        mode("set_min");
        for (int i = 1; i <= 30; i++) begin
            cycle_in(1'b0, 1'b1, 1'b0);
            e_al[15:8] = bcd(i);
            chk("set_min_inc");
        end
        cycle_in(1'b1, 1'b1, 1'b0);
        e_sel = 2'd3;
        chk("mode_wins");
        for (int i = 1; i <= 7; i++) begin
            cycle_in(1'b0, 1'b1, 1'b0);
            e_al[23:16] = bcd(i);
            chk("set_hour_inc");
        end
        mode("set_done");
        e_al = 24'h073005;
        chk("alarm_value");

        alarm_en = 1'b1;
        cycle_in(1'b0, 1'b0, 1'b0);
        cur_t = 24'h073005;
        cycle_in(1'b0, 1'b0, 1'b0);
        chk("match_latency");
        cycle_in(1'b0, 1'b0, 1'b0);
        e_ring = 1'b1;
        chk("ring_on");
        cycle_in(1'b0, 1'b0, 1'b1); chk("ring_tick1");
        cycle_in(1'b0, 1'b0, 1'b1); chk("ring_tick2");
        cycle_in(1'b0, 1'b0, 1'b1); e_ring = 1'b0; chk("ring_expire");
        for (int i = 0; i < 3; i++) begin
            cycle_in(1'b0, 1'b0, 1'b0);
            chk("no_retrigger");
        end

        retrigger(1'b1, "trigger_with_tick");
        cycle_in(1'b0, 1'b0, 1'b1); chk("load_tick1");
        cycle_in(1'b0, 1'b0, 1'b1); chk("load_tick2");
        cycle_in(1'b0, 1'b0, 1'b1); e_ring = 1'b0; chk("load_expire");

        retrigger(1'b0, "retrigger_up");
        cycle_in(1'b0, 1'b1, 1'b0);
        e_ring = 1'b0;
        chk("dismiss_up");
        for (int i = 0; i < 2; i++) begin
            cycle_in(1'b0, 1'b0, 1'b0);
            chk("held_no_retrigger");
        end

        retrigger(1'b0, "retrigger_mode");
        cycle_in(1'b1, 1'b0, 1'b0);
        e_ring = 1'b0;
        chk("dismiss_mode");

        retrigger(1'b0, "retrigger_en");
        alarm_en = 1'b0;
        cycle_in(1'b0, 1'b0, 1'b0);
        e_ring = 1'b0;
        chk("dismiss_en");
        alarm_en = 1'b1;

        retrigger(1'b0, "retrigger_reset");
        reset = 1'b1;
        cycle_in(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        e_sel = 2'd0; e_al = 24'h000000; e_ring = 1'b0;
        chk("reset_mid_ring");
        cycle_in(1'b0, 1'b0, 1'b0);
        chk("after_reset");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations still queued, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
